// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one single-word I/O register bus among MASTERS requesters (req -> ack in 2 cycles).
// Optional master locking is compiled in with `define IO_ARB_LOCK_EN.
module io_bus_arbiter #(
  parameter int MASTERS  = 2,
  parameter int IO_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTERS-1:0]    m_req,
  input  logic [MASTERS-1:0]    m_we,
`ifdef IO_ARB_LOCK_EN
  input  logic [MASTERS-1:0]    m_lock,
`endif
  input  logic [32*MASTERS-1:0] m_addr,
  input  logic [32*MASTERS-1:0] m_wdata,
  output logic [MASTERS-1:0]    m_ack,
  output logic                  m_err,
  output logic [31:0]           m_rdata,
  output logic [31:0]           bus_addr,
  output logic                  bus_we,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata
);
  localparam int IDXW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     ptr_q, ptr_d, win_q, win_d;
  logic                we_q, we_d, ok_q, ok_d;
  logic [MASTERS-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         baddr_q, baddr_d, bwdata_q, bwdata_d;
  logic                bwe_q, bwe_d;
`ifdef IO_ARB_LOCK_EN
  logic                lock_vld_q, lock_vld_d, lock_bit_q, lock_bit_d, lock_win_q, lock_win_d;
  logic [IDXW-1:0]     lock_own_q, lock_own_d;
`endif

  logic                found;
  logic                grant_locked;
  logic [IDXW-1:0]     winner;
  logic [31:0]         sel_addr, sel_wdata;
  logic                sel_ok;
  int                  idx;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    we_d         = we_q;
    ok_d         = ok_q;
    ack_d        = '0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    baddr_d      = baddr_q;
    bwe_d        = bwe_q;
    bwdata_d     = bwdata_q;
    found        = 1'b0;
    grant_locked = 1'b0;
    winner       = '0;
    idx          = 0;
`ifdef IO_ARB_LOCK_EN
    lock_vld_d   = lock_vld_q;
    lock_own_d   = lock_own_q;
    lock_bit_d   = lock_bit_q;
    lock_win_d   = lock_win_q;
    if (lock_vld_q) begin
      if (m_req[lock_own_q]) begin
        found        = 1'b1;
        grant_locked = 1'b1;
        winner       = lock_own_q;
      end else if (state_q == IDLE) begin
        lock_vld_d = 1'b0;
      end
    end
`endif
    // First requester at or after ptr, wrapping.
    for (int i = 0; i < MASTERS; i++) begin
      idx = (int'(ptr_q) + i) % MASTERS;
      if (!found && m_req[IDXW'(idx)]) begin
        found  = 1'b1;
        winner = IDXW'(idx);
      end
    end
    sel_addr  = m_addr[32*int'(winner) +: 32];
    sel_wdata = m_wdata[32*int'(winner) +: 32];
    sel_ok    = (sel_addr[1:0] == 2'b00) && (sel_addr < 32'(4*IO_WORDS));

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ACCESS;
          win_d    = winner;
          we_d     = m_we[winner];
          ok_d     = sel_ok;
          baddr_d  = sel_ok ? sel_addr : 32'h0;
          bwe_d    = sel_ok & m_we[winner];
          bwdata_d = sel_ok ? sel_wdata : 32'h0;
`ifdef IO_ARB_LOCK_EN
          lock_bit_d = m_lock[winner];
          lock_win_d = grant_locked;
          if (m_lock[winner]) begin
            lock_vld_d = 1'b1;
            lock_own_d = winner;
          end
`endif
        end
      end
      ACCESS: begin
        state_d       = RESP;
        ack_d[win_q]  = 1'b1;
        err_d         = ~ok_q;
        rdata_d       = (ok_q && !we_q) ? bus_rdata : 32'h0;
        baddr_d       = 32'h0;
        bwe_d         = 1'b0;
        bwdata_d      = 32'h0;
      end
      default: begin
        state_d = IDLE;
`ifdef IO_ARB_LOCK_EN
        if (lock_vld_q && (lock_own_q == win_q) && !lock_bit_q)
          lock_vld_d = 1'b0;
        // A grant won through the lock leaves the rotation where it was.
        if (!lock_win_q)
          ptr_d = IDXW'((int'(win_q) + 1) % MASTERS);
`else
        ptr_d = IDXW'((int'(win_q) + 1) % MASTERS);
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      ok_q     <= 1'b0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      baddr_q  <= 32'h0;
      bwe_q    <= 1'b0;
      bwdata_q <= 32'h0;
`ifdef IO_ARB_LOCK_EN
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      lock_bit_q <= 1'b0;
      lock_win_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      ok_q     <= ok_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      baddr_q  <= baddr_d;
      bwe_q    <= bwe_d;
      bwdata_q <= bwdata_d;
`ifdef IO_ARB_LOCK_EN
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_bit_q <= lock_bit_d;
      lock_win_q <= lock_win_d;
`endif
    end
  end

  assign m_ack     = ack_q;
  assign m_err     = err_q;
  assign m_rdata   = rdata_q;
  assign bus_addr  = baddr_q;
  assign bus_we    = bwe_q;
  assign bus_wdata = bwdata_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with a small I/O register model and an expected-ack scoreboard.
module tb_io_bus_arbiter;
  localparam int M  = 2;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [M-1:0]    m_req, m_we;
  logic [32*M-1:0] m_addr, m_wdata;
  logic [M-1:0]    m_ack;
  logic            m_err;
  logic [31:0]     m_rdata, bus_addr, bus_wdata, bus_rdata;
  logic            bus_we;
`ifdef IO_ARB_LOCK_EN
  logic [M-1:0]    m_lock;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [16] = '{0: 32'h11, 2: 32'hA5A5, 3: 32'h155, default: 32'h0};

  io_bus_arbiter #(.MASTERS(M), .IO_WORDS(16)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we),
`ifdef IO_ARB_LOCK_EN
    .m_lock(m_lock),
`endif
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // I/O registers: write has no reset gating, read is combinational.
  always @(posedge clk) if (bus_we) mem[bus_addr[5:2]] <= bus_wdata;
  assign bus_rdata = mem[bus_addr[5:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int m, input logic e, input logic [31:0] d);
    exp_t x;
    x.m = m; x.err = e; x.rdata = d;
    sb.push_back(x);
  endtask

  task automatic drive(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    m_req[IW'(m)]      = 1'b1;
    m_we[IW'(m)]       = we;
    m_addr[32*m +: 32]  = a;
    m_wdata[32*m +: 32] = d;
  endtask

  task automatic drop(input int m);
    m_req[IW'(m)] = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_ack(input int budget, output int waited);
    exp_t x;
    bit   seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge clk);
      if (m_ack != '0) begin
        seen   = 1'b1;
        waited = i;
      end
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow: observed ack %b expected none", m_ack);
    end else begin
      x = sb.pop_front();
      check("ack_onehot", 32'(m_ack), 32'(1 << x.m));
      check("ack_err", 32'(m_err), 32'(x.err));
      check("ack_rdata", m_rdata, x.rdata);
      check("ack_bus_idle", 32'(bus_we), 32'h0);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
`ifdef IO_ARB_LOCK_EN
    m_lock = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(m_ack), 32'h0);
    check("rst_err", 32'(m_err), 32'h0);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single write by master0.
    drive(0, 1'b1, 32'd4, 32'h3FF); push(0, 1'b0, 32'h0);
    @(negedge clk);
    check("wr_bus_we", 32'(bus_we), 32'h1);
    check("wr_bus_addr", bus_addr, 32'd4);
    check("wr_bus_wdata", bus_wdata, 32'h3FF);
    check("wr_no_early_ack", 32'(m_ack), 32'h0);
    expect_ack(4, w);
    check("wr_latency", 32'(w + 1), 32'd2);
    drop(0);

    // Single read by master1.
    drive(1, 1'b0, 32'd12, 32'h0); push(1, 1'b0, 32'h155);
    @(negedge clk);
    check("rd_bus_addr", bus_addr, 32'd12);
    check("rd_bus_we", 32'(bus_we), 32'h0);
    expect_ack(4, w);
    check("rd_latency", 32'(w + 1), 32'd2);
    drop(1);

    // Read back the earlier write.
    drive(1, 1'b0, 32'd4, 32'h0); push(1, 1'b0, 32'h3FF);
    expect_ack(5, w);
    check("rb_latency", 32'(w), 32'd2);
    drop(1);

    // Address errors: out of range, misaligned, invalid write.
    drive(0, 1'b0, 32'd64, 32'h0); push(0, 1'b1, 32'h0);
    @(negedge clk);
    check("err64_bus_we", 32'(bus_we), 32'h0);
    check("err64_bus_addr", bus_addr, 32'h0);
    expect_ack(4, w);
    drop(0);
    drive(1, 1'b0, 32'd6, 32'h0); push(1, 1'b1, 32'h0);
    @(negedge clk);
    check("err6_bus_we", 32'(bus_we), 32'h0);
    expect_ack(4, w);
    drop(1);
    drive(0, 1'b1, 32'd64, 32'hDEADBEEF); push(0, 1'b1, 32'h0);
    @(negedge clk);
    check("errwr_bus_we", 32'(bus_we), 32'h0);
    check("errwr_bus_wdata", bus_wdata, 32'h0);
    expect_ack(4, w);
    drop(0);

    // Contention from reset: grants 0,1,0 with acks 3 cycles apart.
    do_reset();
    drive(0, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b0, 32'd8, 32'h0);
    push(0, 1'b0, 32'h11); push(1, 1'b0, 32'hA5A5); push(0, 1'b0, 32'h11);
    expect_ack(5, w); check("cont_lat0", 32'(w), 32'd2);
    expect_ack(5, w); check("cont_lat1", 32'(w), 32'd3);
    expect_ack(5, w); check("cont_lat2", 32'(w), 32'd3);
    m_req = '0;
    @(negedge clk);

    // Reset during ACCESS of a master1 write (ptr is 1 here).
    drive(1, 1'b1, 32'd8, 32'hDEAD);
    @(negedge clk);
    check("mid_bus_we", 32'(bus_we), 32'h1);
    rst = 1'b1; m_req = '0;
    @(negedge clk);
    check("mid_ack", 32'(m_ack), 32'h0);
    check("mid_err", 32'(m_err), 32'h0);
    check("mid_rdata", m_rdata, 32'h0);
    check("mid_bus_we0", 32'(bus_we), 32'h0);
    check("mid_bus_addr", bus_addr, 32'h0);
    check("mid_bus_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_no_ack", 32'(m_ack), 32'h0);
    drive(0, 1'b0, 32'd8, 32'h0);
    drive(1, 1'b0, 32'd0, 32'h0);
    push(0, 1'b0, 32'hDEAD); push(1, 1'b0, 32'h11);
    expect_ack(5, w); check("post_rst_lat", 32'(w), 32'd2);
    m_req[0] = 1'b0;
    expect_ack(5, w); check("post_rst_lat1", 32'(w), 32'd3);
    drop(1);

`ifdef IO_ARB_LOCK_EN
    // Master1 holds the bus for three reads; master0 waits.
    do_reset();
    drive(1, 1'b0, 32'd12, 32'h0); m_lock[1] = 1'b1;
    push(1, 1'b0, 32'h155); push(1, 1'b0, 32'h155); push(1, 1'b0, 32'h155);
    push(0, 1'b0, 32'h11);
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'h0);
    expect_ack(5, w);
    expect_ack(5, w);
    m_lock[1] = 1'b0;
    expect_ack(5, w);
    m_req[1] = 1'b0;
    expect_ack(5, w);
    drop(0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Round-robin arbiter that shares the single memory-mapped I/O register bus (LEDs, switches, buttons, hex displays, GPIO) between several bus masters, e.g. the CPU data port and a debug/DMA master. Each master issues one single-word read or write through a req/ack handshake. The arbiter drives the bus in a one-cycle access slot, captures the read data, and returns it with a one-cycle acknowledge. Tristate glue stays at top level: the bus data line is driven with bus_wdata when bus_we=1, else released.

## Interface
- MASTERS, 2, number of requesters (2..4)
- IO_WORDS, 16, number of 32-bit words in the I/O map; valid byte addresses 0 .. 4*IO_WORDS-4
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  MASTERS  per-master request; held until that master's ack
- m_we  in  MASTERS  per-master write strobe (1 = write, 0 = read)
- m_addr  in  32*MASTERS  per-master byte address; master i occupies bits [32*i+31:32*i]
- m_wdata  in  32*MASTERS  per-master write data, same packing
- m_ack  out  MASTERS  one-hot, one-cycle completion pulse
- m_err  out  1  valid with m_ack; 1 = address rejected
- m_rdata  out  32  read data, valid in the ack cycle
- bus_addr  out  32  I/O bus byte address
- bus_we  out  1  I/O bus write enable
- bus_wdata  out  32  I/O bus write data
- bus_rdata  in  32  I/O bus read data (combinational from the bus)

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any m_req is set, select a winner by round-robin: the first requesting index at or after ptr, wrapping modulo MASTERS.
  - Latch the winner's index, we, addr and wdata; go to ACCESS.
  - If no request is set, stay in IDLE.
- ACCESS:
  - Valid address (addr[1:0]==0 and addr < 4*IO_WORDS): drive bus_addr/bus_we/bus_wdata from the latched values. For a read, register bus_rdata into m_rdata at the end of the cycle.
  - Invalid address: keep the bus idle (bus_we=0) and set the err flag.
  - Always go to RESP.
- RESP:
  - Assert m_ack[winner]=1, plus m_err if flagged. m_rdata=0 for writes and errors.
  - Update ptr = (winner+1) mod MASTERS; go to IDLE.
  - m_req is ignored in RESP.
- Bus idle value outside ACCESS: bus_addr=0, bus_we=0, bus_wdata=0. A read of address 0 has no side effects.
- The master must drop m_req, or present a new transaction, in the cycle after its ack. A request still high in the following IDLE cycle is treated as a new transaction.
- Changing m_addr/m_we/m_wdata while m_req is high has no effect once the winner is latched.
- A request deasserted in IDLE before grant is simply not serviced.

## Timing
- Latency: m_req seen high in IDLE at cycle N gives bus access at N+1 and m_ack at N+2.
- Maximum throughput is one transaction per 3 cycles.
- A write commits into the I/O registers on the clock edge ending the ACCESS cycle.
- m_rdata holds its value until the next RESP.
- Reset values: state=IDLE, ptr=0, m_ack=0, m_err=0, m_rdata=0, bus_addr=0, bus_we=0, bus_wdata=0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A write in ACCESS whose edge coincides with rst=1 is still seen by the bus, because the bus's own register write has no reset gating; masters must reissue after reset.
- Simultaneous requests: ptr decides priority, so with all masters requesting continuously the grants rotate 0,1,..,MASTERS-1,0.

## Configuration
- IO_ARB_LOCK_EN defined:
  - Adds input m_lock [MASTERS-1:0].
  - If the winner's m_lock was 1 at latch time, that master becomes lock owner.
  - While a lock owner exists and its m_req is high in IDLE, it wins regardless of ptr, and ptr does not advance.
  - Lock clears when the owner completes a transaction latched with m_lock=0, when the owner's m_req is low in any IDLE cycle, or on reset.
- IO_ARB_LOCK_EN undefined: no m_lock port; pure round-robin.

## Test plan
- Single write: master0 writes 0x3FF to address 4 → bus_we=1 and bus_addr=4 for one cycle, m_ack[0] two cycles after req, m_err=0.
- Single read: master1 reads address 12 with bus_rdata=0x00000155 → m_ack[1] with m_rdata=0x155 two cycles after req.
- Contention: both masters request continuously from reset with distinct addresses → grant order 0,1,0,1; each ack 3 cycles apart; no master starves.
- Error: read address 64, and separately read address 6 → bus_we stays 0, m_ack with m_err=1 and m_rdata=0.
- Reset mid-op: assert rst during ACCESS → no m_ack; all outputs 0 the next cycle; the next request is granted to master0.
- With IO_ARB_LOCK_EN: master1 issues 3 locked reads while master0 requests continuously → master1 gets all three; master0 is granted after master1 unlocks.
